// File: rtl/rf_wb_scoreboard.sv
// Register-file scoreboard and single-write-port arbiter: tracks in-flight writes per
// register to stall issue on RAW/WAW-overflow, and shares the RF write port between A and B.
module rf_wb_scoreboard #(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [4:0]  iss_rs1,
    input  logic [4:0]  iss_rs2,
    input  logic [4:0]  iss_rd,
    input  logic        iss_use_rs1,
    input  logic        iss_use_rs2,
    input  logic        iss_wr,
    input  logic        wa_valid,
    input  logic [4:0]  wa_rd,
    input  logic [31:0] wa_data,
    output logic        wa_ready,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        pend_any,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [3:0]       STARVE_T = 4'(STARVE_MAX);

    // cnt[0] exists only to keep indexing uniform; it never leaves zero.
    logic [CNT_W-1:0] cnt [32];
    logic [3:0]       starve;
    logic             err_q;

    logic             grant_b;
    logic             iss_fire;
    logic             commit_nz;
    logic [31:0]      inc_vec;
    logic [31:0]      dec_vec;

    // B takes the port only when it is alone or has been refused STARVE_MAX times.
    assign grant_b  = wb_valid && (!wa_valid || (starve == STARVE_T));
    assign wb_ready = grant_b;
    assign wa_ready = wa_valid && !grant_b;
    assign rf_we    = wa_valid || wb_valid;
    assign rf_a3    = grant_b ? wb_rd   : wa_rd;
    assign rf_wd    = grant_b ? wb_data : wa_data;

    assign commit_nz = rf_we && (rf_a3 != 5'd0);
    assign err       = err_q;

    always_comb begin
        iss_ready = 1'b1;
        if (iss_use_rs1 && (iss_rs1 != 5'd0) && (cnt[iss_rs1] != '0))
            iss_ready = 1'b0;
        if (iss_use_rs2 && (iss_rs2 != 5'd0) && (cnt[iss_rs2] != '0))
            iss_ready = 1'b0;
        if (iss_wr && (iss_rd != 5'd0) && (cnt[iss_rd] == CNT_MAX))
            iss_ready = 1'b0;
    end

    assign iss_fire = iss_valid && iss_ready && iss_wr && (iss_rd != 5'd0);

    always_comb begin
        inc_vec  = '0;
        dec_vec  = '0;
        pend_any = 1'b0;
        for (int r = 1; r < 32; r++) begin
            inc_vec[r] = iss_fire  && (iss_rd == 5'(r));
            dec_vec[r] = commit_nz && (rf_a3  == 5'(r));
        end
        for (int r = 0; r < 32; r++)
            pend_any = pend_any | (cnt[r] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++)
                cnt[r] <= '0;
            starve <= '0;
            err_q  <= 1'b0;
        end else begin
            // Simultaneous issue and commit on one register cancel out.
            for (int r = 0; r < 32; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_vec[r] && !inc_vec[r] && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
            if (commit_nz && (cnt[rf_a3] == '0))
                err_q <= 1'b1;
            if (!wb_valid || grant_b)
                starve <= '0;
            else if (starve != STARVE_T)
                starve <= starve + 4'd1;
        end
    end

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard: hazards, WAW saturation, arbitration fairness,
// x0 handling, sticky error and asynchronous reset.
module tb_rf_wb_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_rs1, iss_rs2, iss_rd;
    logic        iss_use_rs1, iss_use_rs2, iss_wr;
    logic        wa_valid, wa_ready;
    logic [4:0]  wa_rd;
    logic [31:0] wa_data;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        pend_any, err;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_scoreboard #(.STARVE_MAX(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2), .iss_wr(iss_wr),
        .wa_valid(wa_valid), .wa_rd(wa_rd), .wa_data(wa_data), .wa_ready(wa_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .pend_any(pend_any), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        iss_use_rs1 = 0; iss_use_rs2 = 0; iss_wr = 0;
        wa_valid = 0; wa_rd = 0; wa_data = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        iss_valid = 1; iss_wr = 1; iss_rd = rd;
        iss_use_rs1 = 0; iss_use_rs2 = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        #2;
        check("rst_pend", pend_any, 0);
        check("rst_ready", iss_ready, 1);
        check("rst_err", err, 0);
        check("rst_we_idle", rf_we, 0);
        wa_valid = 1; wb_valid = 1;
        #1;
        check("rst_wa_ready", wa_ready, 1);
        check("rst_wb_ready", wb_ready, 0);
        check("rst_we", rf_we, 1);
        idle_inputs();
        #10;
        rst_n = 1;
        tick();

        // RAW hazard on r5 and release after commit.
        issue_wr(5);
        #1 check("raw_issue_ready", iss_ready, 1);
        tick();
        iss_wr = 0; iss_use_rs1 = 1; iss_rs1 = 5;
        wa_valid = 1; wa_rd = 5; wa_data = 32'h1234;
        #1;
        check("raw_stall", iss_ready, 0);
        check("raw_pend", pend_any, 1);
        check("raw_we", rf_we, 1);
        check("raw_a3", rf_a3, 5);
        check("raw_wd", rf_wd, 32'h1234);
        check("raw_wa_ready", wa_ready, 1);
        tick();
        wa_valid = 0;
        #1;
        check("raw_release", iss_ready, 1);
        check("raw_pend_clear", pend_any, 0);
        idle_inputs();

        // WAW counter saturation on r7 (max 3 in flight).
        for (int i = 0; i < 3; i++) begin
            issue_wr(7);
            #1 check("waw_issue_ok", iss_ready, 1);
            tick();
        end
        wa_valid = 1; wa_rd = 7; wa_data = 32'h7;
        #1 check("waw_full", iss_ready, 0);
        tick();
        iss_valid = 0; wa_valid = 0;
        #1 check("waw_after_commit", iss_ready, 1);
        wa_valid = 1;
        tick();
        tick();
        wa_valid = 0;
        #1;
        check("waw_drained", pend_any, 0);
        check("waw_err", err, 0);
        idle_inputs();

        // Arbitration under continuous A and B traffic to x0.
        wa_valid = 1; wa_data = 32'hAAAA;
        wb_valid = 1; wb_data = 32'hBBBB;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("arb_wb_ready", wb_ready, (i % 5 == 4) ? 1 : 0);
            check("arb_wa_ready", wa_ready, (i % 5 == 4) ? 0 : 1);
            check("arb_wd", rf_wd, (i % 5 == 4) ? 32'hBBBB : 32'hAAAA);
            tick();
        end
        idle_inputs();

        // x0 is never tracked.
        issue_wr(0);
        wa_valid = 1; wa_rd = 0; wa_data = 32'h55;
        #1;
        check("x0_we", rf_we, 1);
        check("x0_a3", rf_a3, 0);
        tick();
        idle_inputs();
        #1;
        check("x0_pend", pend_any, 0);
        check("x0_err", err, 0);

        // Same-cycle issue and commit on r9 leaves the count at 1.
        issue_wr(9);
        tick();
        wb_valid = 1; wb_rd = 9; wb_data = 32'h99;
        #1 check("same_wb_ready", wb_ready, 1);
        tick();
        idle_inputs();
        iss_use_rs2 = 1; iss_rs2 = 9;
        #1;
        check("same_stall", iss_ready, 0);
        check("same_pend", pend_any, 1);
        wa_valid = 1; wa_rd = 9;
        tick();
        idle_inputs();
        #1;
        check("same_drained", pend_any, 0);
        check("same_err", err, 0);

        // Commit to an idle register sets the sticky error.
        wa_valid = 1; wa_rd = 3;
        tick();
        idle_inputs();
        #1 check("err_set", err, 1);
        issue_wr(4);
        tick();
        idle_inputs();
        tick();
        check("err_sticky", err, 1);
        check("err_pend4", pend_any, 1);
        #3 rst_n = 0;
        #1;
        check("async_err", err, 0);
        check("async_pend", pend_any, 0);
        #3 rst_n = 1;
        tick();
        wa_valid = 1; wa_rd = 4;
        tick();
        idle_inputs();
        #1 check("late_commit_err", err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_wb_scoreboard.md
# rf_wb_scoreboard

Scoreboard and writeback-port arbiter for the pipelined core's 32 x 32 register file. Sits between decode/issue and the register file's single write port. It tracks in-flight writes per architectural register and stalls issue on RAW hazards and WAW counter overflow. It also arbitrates the single RF write port between the single-cycle ALU writeback path (A) and the long-latency load/mul-div path (B), with starvation protection for B.

## Interface
- STARVE_MAX, 4: consecutive cycles B may be refused before it wins priority (1..15)
- CNT_W, 2: width of per-register outstanding-write counter (max 2^CNT_W-1 in flight)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  instruction at issue
- iss_ready  out  1  instruction may issue this cycle
- iss_rs1, iss_rs2, iss_rd  in  5  source/destination register numbers
- iss_use_rs1, iss_use_rs2, iss_wr  in  1  operand-used / writes-rd flags
- wa_valid, wa_rd, wa_data  in  1/5/32  writeback request, source A
- wa_ready  out  1  source A granted
- wb_valid, wb_rd, wb_data  in  1/5/32  writeback request, source B
- wb_ready  out  1  source B granted
- rf_we  out  1  RF write enable (RFWr)
- rf_a3  out  5  RF write address
- rf_wd  out  32  RF write data
- pend_any  out  1  some register has a nonzero counter
- err  out  1  sticky: commit to a register whose counter was 0

## Operation
- State: cnt[1..31] (CNT_W bits each), starve counter (4 bits), err. x0 is never tracked.
- Hazard: iss_ready = 0 if any of:
  - iss_use_rs1 && rs1 != 0 && cnt[rs1] != 0
  - iss_use_rs2 && rs2 != 0 && cnt[rs2] != 0
  - iss_wr && rd != 0 && cnt[rd] == 2^CNT_W-1
  - Otherwise iss_ready = 1. iss_ready does not depend on iss_valid.
- Issue: when iss_valid && iss_ready && iss_wr && rd != 0, cnt[rd] is incremented.
- Arbitration, one grant per cycle:
  - Default priority is A.
  - B wins when starve == STARVE_MAX and wb_valid.
  - The grant goes to whichever requester is valid when only one is.
  - wa_ready / wb_ready reflect the grant. The loser's ready is 0.
- Write: rf_we = wa_valid || wb_valid. rf_a3 and rf_wd are muxed from the granted source. A write to x0 still drives rf_we and never touches counters.
- Commit: when rf_we && rf_a3 != 0, cnt[rf_a3] is decremented.
  - If cnt[rf_a3] == 0, it stays 0 and err is set. err clears only on reset.
- Same register issued and committed in one cycle: counter unchanged (+1 -1). Same-register saturation check uses the pre-edge value; there is no same-cycle bypass.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on wb_valid && !wb_ready.
  - Clears on B grant or when !wb_valid.
- pend_any = OR of all cnt != 0.

## Timing
- All ready, rf_* outputs are combinational from inputs and registered state. Counters, starve and err update on the rising clk edge.
- Hazard release: a commit on edge N lets a dependent instruction issue in the cycle after edge N. It never issues in the commit cycle itself, because the RF write is not visible until after the edge.
- Reset (rst_n low, async): every cnt = 0, starve = 0, err = 0.
  - While held: pend_any = 0, iss_ready = 1, wa_ready = 1 if wa_valid, wb_ready = 1 if wb_valid && !wa_valid, rf_we follows requests.
  - Reset mid-flight discards all tracking. Late commits after reset set err.
- B maximum wait under continuous A traffic: STARVE_MAX refused cycles, then 1 grant cycle.

## Test plan
- Reset, then issue rd=5 (iss_wr=1), next cycle issue use_rs1 rs1=5 -> iss_ready=0. A commits rd=5 with wd=0x1234 -> rf_we=1, rf_a3=5, rf_wd=0x1234. Next cycle iss_ready=1, pend_any=0.
- CNT_W=2: issue rd=7 three times -> fourth issue with rd=7 sees iss_ready=0. One commit to 7 -> iss_ready=1 next cycle.
- wa_valid and wb_valid held high every cycle, STARVE_MAX=4 -> wb_ready=0 for 4 cycles, 1 on the 5th (wa_ready=0 that cycle), then pattern repeats.
- Issue rd=0 and commit to x0 -> counters unchanged, pend_any=0, err=0, rf_we=1 with rf_a3=0.
- Commit to r3 with cnt[3]=0 -> err=1 next cycle and stays 1. Pulse rst_n low mid-cycle -> err, pend_any drop to 0 immediately (async).
- Same-cycle issue rd=9 (cnt[9]=1) and commit r9 -> cnt[9] stays 1. Next cycle use_rs2 rs2=9 -> iss_ready=0.
